cmv300_frame_source: RTL and testbench
======================================

Name: cmv300_frame_source

Overview:
Synthesizable stand-in for the CMV300 sensor output side, for bring-up and regression of the camera capture path without the physical sensor.
- Generates the pixel clock, LVAL/DVAL and 10-bit pixel data in response to frame-request pulses.
- Sits in place of the sensor pins and feeds the existing capture logic, which samples on the falling edge of the pixel clock.
- Supplies deterministic test patterns so captured frames can be checked bit-exactly on the PC.

Parameters:
H_ACTIVE, 648, active pixels per line
V_ACTIVE, 488, active lines per frame
H_BLANK, 16, pixel-clock periods with LVAL low between lines
FOT, 32, pixel-clock periods from accepted request to first LVAL
CLK_DIV, 5, clk cycles per pixel-clock half-period (must be >= 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_req  in  1  frame request, one-clk pulse (clk domain)
pattern_sel  in  2  pattern select; sampled when a frame starts
pix_clk_out  out  1  pixel clock, 50% duty, period 2*CLK_DIV clk
lval  out  1  line valid
dval  out  1  data valid (equal to lval in this block)
pix_data  out  10  pixel data
busy  out  1  frame in progress (FOT through last line)
frame_cnt  out  16  completed frames, wraps 0xFFFF->0
req_dropped  out  1  sticky: a request arrived while one was already pending

Behaviour:
- Reset (async assert, sync release): all outputs 0; divider 0; state IDLE; pending cleared.
- Pixel clock divider:
  - Counter runs 0..CLK_DIV-1; pix_clk_out toggles when the count reaches CLK_DIV-1.
  - rise_tick is the clk cycle in which pix_clk_out goes 0->1.
  - All state, lval, dval and pix_data updates occur only on rise_tick, so data is stable across the falling edge.
- Request handling (any clk cycle):
  - In IDLE, frame_req sets a start flag consumed at the next rise_tick.
  - While busy, the first request sets pending. A further request while pending is set leaves pending set and sets req_dropped.
  - req_dropped is cleared only by reset.
- FSM (transitions on rise_tick):
  - IDLE: if the start flag or pending is set, clear it, latch pattern_sel, row=0, cnt=0, go to FOT. busy goes 1.
  - FOT: count FOT ticks, then go to LINE with col=0.
  - LINE: lval=dval=1 and pix_data=pattern(row,col). col increments each tick. After col=H_ACTIVE-1, go to HBLANK with cnt=0.
  - HBLANK: lval=dval=0 and pix_data=0 for H_BLANK ticks. Then, if row=V_ACTIVE-1, go to DONE; otherwise row+1 and go to LINE.
  - DONE: one tick. frame_cnt+1, busy=0, go to IDLE. A pending request starts at the next rise_tick, so inter-frame gap >= 2 ticks.
- Patterns (10-bit, truncate modulo 1024):
  - 0: row+col
  - 1: col
  - 2: constant 0x2AA
  - 3: (col[3] XOR row[3]) ? 0x3FF : 0x000
- pattern_sel changes mid-frame have no effect until the next frame.
- frame_req in the same clk as the DONE tick is latched as pending; it is not dropped.
- Widths: row and col counters are 12 bits; H_ACTIVE and V_ACTIVE <= 4095.

Decomposition:
- Shared package cmv300_pkg holds:
  - FSM state enum (IDLE, FOT, LINE, HBLANK, DONE)
  - pattern encodings
  - pixel width constant (10)
- One sub-module, cmv300_pix_clk_gen: the divider, producing pix_clk_out and rise_tick.
- Pattern logic stays inline as a combinational function.

Test Plan:
All scenarios use H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, FOT=3, CLK_DIV=2.
- Reset then idle 100 clk -> all outputs 0, pix_clk_out period 4 clk, no lval.
- Single frame_req with pattern 0 -> busy rises; lval is first high 3 rise_ticks after start. Data is 0,1,2,3 / 1,2,3,4 / 2,3,4,5. Lval is low exactly 2 ticks between lines. frame_cnt=1 and busy=0 after the DONE tick.
- Pattern 2, one frame -> 12 samples all 0x2AA; pix_data=0 whenever lval=0.
- Two requests during frame 1 -> the second starts immediately after DONE; req_dropped=0. A third request during frame 1 sets req_dropped=1; frame_cnt=2 at the end.
- Assert rst_n low in mid-LINE -> all outputs 0 immediately (async). No frame resumes after release until a new frame_req.
- Data is captured on the falling edge of pix_clk_out by a bench model of the capture logic, pattern 3 -> all 12 samples match the expected checkerboard values; zero samples are taken while lval=0.

Source files
------------

// File: rtl/cmv300_pkg.sv
// Shared definitions for the CMV300 frame source.
//   state_e   : frame sequencer states
//   pattern_e : test-pattern encodings selected by pattern_sel
//   PIX_W     : pixel data width
package cmv300_pkg;

  localparam int PIX_W = 10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FOT    = 3'd1,
    S_LINE   = 3'd2,
    S_HBLANK = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PAT_DIAG    = 2'd0,  // row + col
    PAT_COL     = 2'd1,  // col
    PAT_CONST   = 2'd2,  // fixed 0x2AA
    PAT_CHECKER = 2'd3   // 8x8 checkerboard
  } pattern_e;

  localparam logic [PIX_W-1:0] PAT_CONST_VAL = 10'h2AA;

endpackage

// File: rtl/cmv300_pix_clk_gen.sv
// Pixel clock divider.
//   clk, rst_n  : system clock, active-low async reset (already synchronised)
//   pix_clk_out : 50% duty clock, period 2*CLK_DIV clk cycles
//   rise_tick   : high in the clk cycle at whose end pix_clk_out goes 0->1
module cmv300_pix_clk_gen
  import cmv300_pkg::*;
#(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_clk_out,
  output logic rise_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          pix_clk_q, pix_clk_d;
  logic          wrap;

  always_comb begin
    wrap      = (div_cnt_q == DIV_LAST);
    div_cnt_d = wrap ? '0 : div_cnt_q + CW'(1);
    pix_clk_d = wrap ? ~pix_clk_q : pix_clk_q;
    rise_tick = wrap & ~pix_clk_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      pix_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_clk_q <= pix_clk_d;
    end
  end

  assign pix_clk_out = pix_clk_q;

endmodule

// File: rtl/cmv300_frame_source.sv
// CMV300 sensor output stand-in: pixel clock, LVAL/DVAL and test-pattern
// pixel data generated per frame request.
//   clk, rst_n   : system clock, active-low async reset
//   frame_req    : one-clk frame request pulse
//   pattern_sel  : pattern, latched when a frame starts
//   pix_clk_out  : pixel clock; all video outputs change on its rising edge
//   lval, dval   : line / data valid (identical)
//   pix_data     : pixel value, 0 outside active lines
//   busy         : frame in progress (FOT through last line)
//   frame_cnt    : completed frames, wrapping
//   req_dropped  : sticky, a request was lost because one was already queued
//
// state  | meaning
// IDLE   | waiting for a start flag or pending request
// FOT    | frame overhead time before the first line
// LINE   | driving active pixels of the current row
// HBLANK | LVAL low between lines
// DONE   | one tick after the last line before returning to IDLE
module cmv300_frame_source
  import cmv300_pkg::*;
#(
  parameter int H_ACTIVE = 648,
  parameter int V_ACTIVE = 488,
  parameter int H_BLANK  = 16,
  parameter int FOT      = 32,
  parameter int CLK_DIV  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_req,
  input  logic [1:0]       pattern_sel,
  output logic             pix_clk_out,
  output logic             lval,
  output logic             dval,
  output logic [PIX_W-1:0] pix_data,
  output logic             busy,
  output logic [15:0]      frame_cnt,
  output logic             req_dropped
);

  localparam logic [11:0] COL_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] ROW_LAST = 12'(V_ACTIVE - 1);
  localparam logic [15:0] FOT_LOAD = 16'(FOT - 1);
  localparam logic [15:0] HB_LOAD  = 16'(H_BLANK - 1);

  // Reset asserts asynchronously and releases two clk edges after rst_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic rise_tick;

  cmv300_pix_clk_gen #(.CLK_DIV(CLK_DIV)) u_pix_clk_gen (
    .clk        (clk),
    .rst_n      (rst_int_n),
    .pix_clk_out(pix_clk_out),
    .rise_tick  (rise_tick)
  );

  function automatic logic [PIX_W-1:0] pattern_px(input pattern_e pat,
                                                  input logic [11:0] row,
                                                  input logic [11:0] col);
    logic [PIX_W-1:0] px;
    case (pat)
      PAT_DIAG:    px = PIX_W'(row + col);
      PAT_COL:     px = PIX_W'(col);
      PAT_CONST:   px = PAT_CONST_VAL;
      PAT_CHECKER: px = (row[3] ^ col[3]) ? '1 : '0;
      default:     px = '0;
    endcase
    return px;
  endfunction

  state_e           state_q, state_d;
  pattern_e         pat_q, pat_d;
  logic [11:0]      row_q, row_d, col_q, col_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             start_q, start_d, pending_q, pending_d;
  logic             req_dropped_q, req_dropped_d;
  logic             lval_q, lval_d, busy_q, busy_d;
  logic [PIX_W-1:0] pix_data_q, pix_data_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    row_d         = row_q;
    col_d         = col_q;
    cnt_d         = cnt_q;
    start_d       = start_q;
    pending_d     = pending_q;
    req_dropped_d = req_dropped_q;
    frame_cnt_d   = frame_cnt_q;

    if (rise_tick) begin
      case (state_q)
        S_IDLE: begin
          if (start_q || pending_q) begin
            if (start_q) start_d   = 1'b0;
            else         pending_d = 1'b0;
            pat_d   = pattern_e'(pattern_sel);
            row_d   = '0;
            col_d   = '0;
            cnt_d   = FOT_LOAD;
            state_d = S_FOT;
          end
        end
        S_FOT: begin
          if (cnt_q == '0) begin
            col_d   = '0;
            state_d = S_LINE;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_LINE: begin
          if (col_q == COL_LAST) begin
            cnt_d   = HB_LOAD;
            state_d = S_HBLANK;
          end else begin
            col_d = col_q + 12'd1;
          end
        end
        S_HBLANK: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 16'd1;
          end else if (row_q == ROW_LAST) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 12'd1;
            col_d   = '0;
            state_d = S_LINE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Judged against the post-tick flags so a request coinciding with a
    // start or with the DONE tick is queued rather than lost.
    if (frame_req) begin
      if (state_d == S_IDLE && !start_d && !pending_d) start_d       = 1'b1;
      else if (!pending_d)                              pending_d     = 1'b1;
      else                                              req_dropped_d = 1'b1;
    end

    // Outputs are registered from the next state so they line up with it.
    if (state_q == S_HBLANK && state_d == S_DONE) frame_cnt_d = frame_cnt_q + 16'd1;
    lval_d     = (state_d == S_LINE);
    pix_data_d = lval_d ? pattern_px(pat_d, row_d, col_d) : '0;
    busy_d     = state_d inside {S_FOT, S_LINE, S_HBLANK};
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= S_IDLE;
      pat_q         <= PAT_DIAG;
      row_q         <= '0;
      col_q         <= '0;
      cnt_q         <= '0;
      start_q       <= 1'b0;
      pending_q     <= 1'b0;
      req_dropped_q <= 1'b0;
      lval_q        <= 1'b0;
      busy_q        <= 1'b0;
      pix_data_q    <= '0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      row_q         <= row_d;
      col_q         <= col_d;
      cnt_q         <= cnt_d;
      start_q       <= start_d;
      pending_q     <= pending_d;
      req_dropped_q <= req_dropped_d;
      lval_q        <= lval_d;
      busy_q        <= busy_d;
      pix_data_q    <= pix_data_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign lval        = lval_q;
  assign dval        = lval_q;
  assign pix_data    = pix_data_q;
  assign busy        = busy_q;
  assign frame_cnt   = frame_cnt_q;
  assign req_dropped = req_dropped_q;

endmodule

// File: tb/tb_cmv300_frame_source.sv
// Bench for cmv300_frame_source: a small instance (4x3 frame, CLK_DIV=2) for
// the directed scenarios and a larger one (20x12, CLK_DIV=1) for randomised
// frames checked against a pattern reference model.
module tb_cmv300_frame_source;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s_req = 1'b0, b_req = 1'b0;
  logic [1:0] s_sel = 2'd0, b_sel = 2'd0;
  logic       s_pix, s_lval, s_dval, s_busy, s_drop;
  logic       b_pix, b_lval, b_dval, b_busy, b_drop;
  logic [9:0] s_data, b_data;
  logic [15:0] s_fcnt, b_fcnt;

  cmv300_frame_source #(.H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .FOT(3), .CLK_DIV(2)) u_small (
    .clk(clk), .rst_n(rst_n), .frame_req(s_req), .pattern_sel(s_sel),
    .pix_clk_out(s_pix), .lval(s_lval), .dval(s_dval), .pix_data(s_data),
    .busy(s_busy), .frame_cnt(s_fcnt), .req_dropped(s_drop));

  localparam int BH = 20, BV = 12;
  cmv300_frame_source #(.H_ACTIVE(BH), .V_ACTIVE(BV), .H_BLANK(3), .FOT(5), .CLK_DIV(1)) u_big (
    .clk(clk), .rst_n(rst_n), .frame_req(b_req), .pattern_sel(b_sel),
    .pix_clk_out(b_pix), .lval(b_lval), .dval(b_dval), .pix_data(b_data),
    .busy(b_busy), .frame_cnt(b_fcnt), .req_dropped(b_drop));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference pattern, straight from the pattern definitions.
  function automatic int ref_px(input int pat, input int r, input int c);
    case (pat)
      0:       return (r + c) % 1024;
      1:       return c % 1024;
      2:       return 682;
      default: return (((c / 8) % 2) != ((r / 8) % 2)) ? 1023 : 0;
    endcase
  endfunction

  // Capture model: samples on falling pixel-clock edges while LVAL is high.
  logic [9:0] s_q[$];
  logic [9:0] b_q[$];
  logic s_pix_prev = 1'b0, b_pix_prev = 1'b0, s_lval_prev = 1'b0, s_busy_prev = 1'b0;
  int mon_cyc = 0, s_rise_cyc = 0, s_fall_cyc = -1, s_busy_cyc = 0;

  always @(negedge clk) begin
    mon_cyc = mon_cyc + 1;
    if (rst_n) begin
      if (s_pix_prev && !s_pix) begin
        if (s_lval) s_q.push_back(s_data);
        else check("s_blank_data", int'(s_data), 0);
      end
      if (b_pix_prev && !b_pix) begin
        if (b_lval) b_q.push_back(b_data);
        else check("b_blank_data", int'(b_data), 0);
      end
      if (s_busy && !s_busy_prev) s_busy_cyc = mon_cyc;
      if (!s_lval && s_lval_prev) begin
        check("s_lval_high_len", mon_cyc - s_rise_cyc, 16);
        s_fall_cyc = mon_cyc;
      end
      if (s_lval && !s_lval_prev) begin
        if (s_fall_cyc > s_busy_cyc) check("s_line_gap", mon_cyc - s_fall_cyc, 8);
        s_rise_cyc = mon_cyc;
      end
      if (s_dval != s_lval) check("s_dval_eq_lval", int'(s_dval), int'(s_lval));
    end
    s_pix_prev  = s_pix;
    b_pix_prev  = b_pix;
    s_lval_prev = s_lval;
    s_busy_prev = s_busy;
  end

  function automatic logic sig(input int id);
    case (id)
      0:       return s_busy;
      1:       return s_lval;
      2:       return s_pix;
      default: return b_busy;
    endcase
  endfunction

  task automatic wait_for(input int id, input logic val, input int max_cyc,
                          input string name, output int n);
    n = 0;
    while (sig(id) !== val && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (sig(id) !== val) check({name, "_timeout"}, int'(sig(id)), int'(val));
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int which);
    if (which == 0) s_req = 1'b1;
    else            b_req = 1'b1;
    @(negedge clk);
    s_req = 1'b0;
    b_req = 1'b0;
  endtask

  typedef struct packed {
    logic [1:0]        pat;
    logic [11:0][9:0]  exp;   // exp[11] is the first captured pixel
  } vec_t;
  vec_t tbl [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, exp_f, pat;

    tbl[0].pat = 2'd0;
    tbl[0].exp = {10'd0, 10'd1, 10'd2, 10'd3, 10'd1, 10'd2, 10'd3, 10'd4, 10'd2, 10'd3, 10'd4, 10'd5};
    tbl[1].pat = 2'd1;
    tbl[1].exp = {3{10'd0, 10'd1, 10'd2, 10'd3}};
    tbl[2].pat = 2'd2;
    tbl[2].exp = {12{10'h2AA}};
    tbl[3].pat = 2'd3;
    tbl[3].exp = '0;

    // Reset and idle
    ticks(3);
    check("reset_outputs", int'({s_pix, s_lval, s_dval, s_data, s_busy, s_fcnt, s_drop}), 0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_lval || s_dval || s_busy || s_data != 10'd0 || s_drop) bad++;
    end
    check("idle_quiet", bad, 0);
    check("idle_fcnt", int'(s_fcnt), 0);
    wait_for(2, 1'b0, 10, "pix_low0", n);
    wait_for(2, 1'b1, 10, "pix_rise", n);
    wait_for(2, 1'b0, 10, "pix_high", n);
    check("pix_high_len", n, 2);
    wait_for(2, 1'b1, 10, "pix_low", n);
    check("pix_low_len", n, 2);

    // One frame per pattern, expected pixels from the table
    exp_f = 0;
    for (int i = 0; i < 4; i++) begin
      s_q.delete();
      s_sel = tbl[i].pat;
      pulse(0);
      wait_for(0, 1'b1, 16, "start", n);
      s_sel = ~tbl[i].pat;
      wait_for(1, 1'b1, 40, "first_lval", n);
      check("fot_latency", n, 12);
      wait_for(0, 1'b0, 200, "frame_end", n);
      exp_f++;
      check("frame_cnt", int'(s_fcnt), exp_f);
      ticks(2);
      check($sformatf("pat%0d_count", i), s_q.size(), 12);
      for (int k = 0; k < 12; k++)
        check($sformatf("pat%0d_px%0d", i, k), (s_q.size() > k) ? int'(s_q[k]) : -1,
              int'(tbl[i].exp[11-k]));
    end

    // Queued requests, request during DONE, dropped request
    s_sel = 2'd0;
    pulse(0);
    wait_for(0, 1'b1, 16, "c_start1", n);
    ticks(10);
    pulse(0);
    wait_for(0, 1'b0, 200, "c_end1", n);
    wait_for(0, 1'b1, 20, "c_start2", n);
    check("back_to_back_gap", n, 8);
    check("c_no_drop", int'(s_drop), 0);
    wait_for(0, 1'b0, 200, "c_end2", n);
    pulse(0);
    wait_for(0, 1'b1, 20, "done_req_start", n);
    check("done_req_gap", n, 7);
    check("c_no_drop2", int'(s_drop), 0);
    wait_for(0, 1'b0, 200, "c_end3", n);
    exp_f += 3;
    check("c_fcnt", int'(s_fcnt), exp_f);
    ticks(6);

    pulse(0);
    wait_for(0, 1'b1, 16, "d3_start1", n);
    ticks(5);
    pulse(0);
    ticks(5);
    check("drop_before_third", int'(s_drop), 0);
    pulse(0);
    ticks(1);
    check("drop_set", int'(s_drop), 1);
    wait_for(0, 1'b0, 200, "d3_end1", n);
    wait_for(0, 1'b1, 20, "d3_start2", n);
    check("d3_gap", n, 8);
    wait_for(0, 1'b0, 200, "d3_end2", n);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_busy || s_lval) bad++;
    end
    check("no_third_frame", bad, 0);
    exp_f += 2;
    check("d3_fcnt", int'(s_fcnt), exp_f);
    check("drop_sticky", int'(s_drop), 1);

    // Asynchronous reset in the middle of a line
    pulse(0);
    wait_for(1, 1'b1, 40, "r_lval", n);
    ticks(2);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({s_pix, s_lval, s_dval, s_data, s_busy, s_drop}), 0);
    check("async_reset_fcnt", int'(s_fcnt), 0);
    ticks(3);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_busy || s_lval || s_fcnt != 16'd0) bad++;
    end
    check("no_resume", bad, 0);

    // Randomised frames on the larger instance
    for (int f = 0; f < 6; f++) begin
      b_q.delete();
      pat = int'($urandom_range(0, 3));
      b_sel = 2'(pat);
      pulse(1);
      wait_for(3, 1'b1, 16, "b_start", n);
      b_sel = 2'($urandom_range(0, 3));
      wait_for(3, 1'b0, 2000, "b_end", n);
      ticks(3);
      check("b_fcnt", int'(b_fcnt), f + 1);
      check("b_count", b_q.size(), BH * BV);
      for (int r = 0; r < BV; r++)
        for (int c = 0; c < BH; c++)
          check($sformatf("b_f%0d_p%0d_r%0d_c%0d", f, pat, r, c),
                (b_q.size() > r * BH + c) ? int'(b_q[r*BH+c]) : -1, ref_px(pat, r, c));
    end
    check("b_no_drop", int'(b_drop), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
